// File: rtl/bus_arbiter.sv
// Hands the cartridge bus between the CoCo CPU and the Arduino: halt the CoCo,
// wait for idle E cycles, insert guard time, grant, then release in reverse order.
module bus_arbiter #(
    parameter int SYNC_STAGES  = 2,
    parameter int HALT_ECYCLES = 3,
    parameter int GUARD_CYCLES = 4,
    parameter int CW           = 12,
    parameter int TIMEOUT      = 4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c_power,
    input  logic       a_power,
    input  logic       eclk,
    input  logic       cts,
    input  logic       scs,
    input  logic       ard_req,
    output logic       busreq,
    output logic       halt_n,
    output logic       ard_gnt,
    output logic       timeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALTING   = 3'd1,
        GUARD_IN  = 3'd2,
        GRANT     = 3'd3,
        GUARD_OUT = 3'd4,
        UNHALT    = 3'd5
    } state_t;

    localparam int NS = 4;
    localparam int HW = $clog2(HALT_ECYCLES + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    // Synchronizer reset values: eclk low, selects inactive (high), no request.
    localparam logic [NS-1:0] SYNC_INIT = 4'b0110;

    logic [NS-1:0] async_in;
    logic [NS-1:0] synced;
    logic          e_s, cts_s, scs_s, req_s, efall;

    assign async_in = {ard_req, scs, cts, eclk};

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg <= {SYNC_STAGES{SYNC_INIT[gi]}};
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in[gi]};
                end
            end
            assign synced[gi] = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    assign e_s   = synced[0];
    assign cts_s = synced[1];
    assign scs_s = synced[2];
    assign req_s = synced[3];

    state_t        state_reg;
    logic          busreq_reg, halt_n_reg, ard_gnt_reg, timeout_reg;
    logic          lockout_reg, e_prev_reg;
    logic [GW-1:0] guard_cnt_reg;
    logic [HW-1:0] halt_cnt_reg;
    logic [CW-1:0] wd_reg;

    assign efall = e_prev_reg & ~e_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            busreq_reg    <= 1'b0;
            halt_n_reg    <= 1'b1;
            ard_gnt_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
            lockout_reg   <= 1'b0;
            e_prev_reg    <= 1'b0;
            guard_cnt_reg <= '0;
            halt_cnt_reg  <= '0;
            wd_reg        <= '0;
        end else begin
            timeout_reg <= 1'b0;
            e_prev_reg  <= e_s;
            if (!req_s) begin
                lockout_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    guard_cnt_reg <= '0;
                    halt_cnt_reg  <= '0;
                    wd_reg        <= '0;
                    if (req_s && !lockout_reg && a_power) begin
                        if (c_power) begin
                            state_reg  <= HALTING;
                            halt_n_reg <= 1'b0;
                        end else begin
                            state_reg  <= GUARD_IN;
                            busreq_reg <= 1'b1;
                        end
                    end
                end
                HALTING: begin
                    if (!a_power || !req_s) begin
                        state_reg     <= UNHALT;
                        guard_cnt_reg <= '0;
                    end else if (efall) begin
                        // Only E cycles with no cartridge select active count as idle.
                        if (cts_s && scs_s) begin
                            if (halt_cnt_reg == HW'(HALT_ECYCLES - 1)) begin
                                state_reg     <= GUARD_IN;
                                busreq_reg    <= 1'b1;
                                guard_cnt_reg <= '0;
                            end else begin
                                halt_cnt_reg <= halt_cnt_reg + HW'(1);
                            end
                        end else begin
                            halt_cnt_reg <= '0;
                        end
                    end
                end
                GUARD_IN: begin
                    if (!a_power) begin
                        state_reg     <= UNHALT;
                        busreq_reg    <= 1'b0;
                        guard_cnt_reg <= '0;
                    end else if (guard_cnt_reg == GW'(GUARD_CYCLES - 1)) begin
                        state_reg   <= GRANT;
                        ard_gnt_reg <= 1'b1;
                        wd_reg      <= '0;
                    end else begin
                        guard_cnt_reg <= guard_cnt_reg + GW'(1);
                    end
                end
                GRANT: begin
                    if (!a_power) begin
                        state_reg     <= UNHALT;
                        busreq_reg    <= 1'b0;
                        ard_gnt_reg   <= 1'b0;
                        guard_cnt_reg <= '0;
                    end else if (wd_reg == CW'(TIMEOUT - 1)) begin
                        // Watchdog wins over a simultaneous request drop.
                        state_reg     <= GUARD_OUT;
                        ard_gnt_reg   <= 1'b0;
                        timeout_reg   <= 1'b1;
                        lockout_reg   <= 1'b1;
                        guard_cnt_reg <= '0;
                    end else if (!req_s) begin
                        state_reg     <= GUARD_OUT;
                        ard_gnt_reg   <= 1'b0;
                        guard_cnt_reg <= '0;
                    end else begin
                        wd_reg <= wd_reg + CW'(1);
                    end
                end
                GUARD_OUT: begin
                    if (!a_power) begin
                        state_reg     <= UNHALT;
                        busreq_reg    <= 1'b0;
                        guard_cnt_reg <= '0;
                    end else if (guard_cnt_reg == GW'(GUARD_CYCLES - 1)) begin
                        busreq_reg    <= 1'b0;
                        guard_cnt_reg <= '0;
                        // With the CoCo unpowered there is nothing to unhalt.
                        if (c_power) begin
                            state_reg <= UNHALT;
                        end else begin
                            state_reg  <= IDLE;
                            halt_n_reg <= 1'b1;
                        end
                    end else begin
                        guard_cnt_reg <= guard_cnt_reg + GW'(1);
                    end
                end
                UNHALT: begin
                    busreq_reg <= 1'b0;
                    if (guard_cnt_reg == GW'(GUARD_CYCLES - 1)) begin
                        state_reg  <= IDLE;
                        halt_n_reg <= 1'b1;
                    end else begin
                        guard_cnt_reg <= guard_cnt_reg + GW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busreq  = busreq_reg;
    assign halt_n  = halt_n_reg;
    assign ard_gnt = ard_gnt_reg;
    assign timeout = timeout_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: every output transition is matched, in order,
// against an expected (signal, value, clk edge) event queued when stimulus is driven.
module tb_bus_arbiter;

    localparam int SYNC_STAGES  = 2;
    localparam int HALT_ECYCLES = 3;
    localparam int GUARD_CYCLES = 4;
    localparam int CW           = 12;
    localparam int TIMEOUT      = 4000;
    localparam int G            = GUARD_CYCLES;
    // Input change to FSM reaction: synchronizer stages plus the state register.
    localparam int LAT          = SYNC_STAGES + 1;

    localparam int ID_BUSREQ  = 0;
    localparam int ID_HALT_N  = 1;
    localparam int ID_GNT     = 2;
    localparam int ID_TIMEOUT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       c_power = 1'b0;
    logic       a_power = 1'b0;
    logic       eclk = 1'b0;
    logic       cts = 1'b1;
    logic       scs = 1'b1;
    logic       ard_req = 1'b0;
    logic       busreq, halt_n, ard_gnt, timeout;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    typedef struct {
        int code;   // signal id * 2 + new value
        int at;     // clk edge number that produces the change
    } evt_t;
    evt_t exp_q[$];

    bus_arbiter #(
        .SYNC_STAGES (SYNC_STAGES),
        .HALT_ECYCLES(HALT_ECYCLES),
        .GUARD_CYCLES(GUARD_CYCLES),
        .CW          (CW),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .c_power(c_power),
        .a_power(a_power),
        .eclk   (eclk),
        .cts    (cts),
        .scs    (scs),
        .ard_req(ard_req),
        .busreq (busreq),
        .halt_n (halt_n),
        .ard_gnt(ard_gnt),
        .timeout(timeout),
        .state  (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int id, input int val, input int at);
        exp_q.push_back('{id * 2 + val, at});
    endtask

    // Monitor: outputs are registered, so sampling on the falling edge is safe.
    logic [3:0] prev;
    always @(negedge clk) begin
        logic [3:0] cur;
        evt_t       e;
        cur = {timeout, ard_gnt, halt_n, busreq};
        if (mon_on) begin
            for (int i = 0; i < 4; i++) begin
                if (cur[i] !== prev[i]) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious", 32'(i * 2) + 32'(cur[i]), 32'd99);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("event", 32'(i * 2) + 32'(cur[i]), 32'(e.code));
                        check_eq("edge", 32'(cyc), 32'(e.at));
                    end
                end
            end
        end
        prev = cur;
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Raise E for 4 clk, then drop it; dirty=1 holds SCS low across the fall.
    task automatic e_fall(input bit dirty, output int f);
        eclk = 1'b1;
        repeat (4) @(negedge clk);
        eclk = 1'b0;
        scs  = dirty ? 1'b0 : 1'b1;
        f    = cyc;
    endtask

    task automatic e_settle();
        repeat (4) @(negedge clk);
        scs = 1'b1;
    endtask

    task automatic check_outputs_reset(input string tag);
        check_eq({tag, "_busreq"}, 32'(busreq), 32'd0);
        check_eq({tag, "_halt_n"}, 32'(halt_n), 32'd1);
        check_eq({tag, "_gnt"}, 32'(ard_gnt), 32'd0);
        check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
        check_eq({tag, "_state"}, 32'(state), 32'd0);
    endtask

    task automatic release_halted();
        int r;
        r = cyc;
        ard_req = 1'b0;
        push(ID_GNT, 0, r + LAT);
        push(ID_BUSREQ, 0, r + LAT + G);
        push(ID_HALT_N, 1, r + LAT + 2 * G);
        wait_cyc(r + LAT + 2 * G + 2);
        check_eq("idle_after_unhalt", 32'(state), 32'd0);
    endtask

    task automatic release_off();
        int r;
        r = cyc;
        ard_req = 1'b0;
        push(ID_GNT, 0, r + LAT);
        push(ID_BUSREQ, 0, r + LAT + G);
        wait_cyc(r + LAT + G + 1);
        check_eq("idle_skip_unhalt", 32'(state), 32'd0);
    endtask

    task automatic request_off(output int k);
        k = cyc;
        ard_req = 1'b1;
        push(ID_BUSREQ, 1, k + LAT);
        // First sampling edge is k+1; grant follows GUARD_CYCLES+2 edges later.
        push(ID_GNT, 1, k + 1 + GUARD_CYCLES + 2);
    endtask

    initial begin
        int k, f, p;
        #1 rst = 1'b1;
        c_power = 1'b1;
        a_power = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_reset("reset");
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (3) @(negedge clk);

        // Normal halted handoff with three clean E cycles.
        k = cyc;
        ard_req = 1'b1;
        push(ID_HALT_N, 0, k + LAT);
        wait_cyc(k + LAT);
        e_fall(1'b0, f); e_settle();
        e_fall(1'b0, f); e_settle();
        e_fall(1'b0, f);
        push(ID_BUSREQ, 1, f + LAT);
        push(ID_GNT, 1, f + LAT + G);
        e_settle();
        wait_cyc(f + LAT + G + 2);
        check_eq("grant_state", 32'(state), 32'd3);
        release_halted();
        repeat (3) @(negedge clk);

        // SCS active on the 2nd E fall restarts the idle count.
        k = cyc;
        ard_req = 1'b1;
        push(ID_HALT_N, 0, k + LAT);
        wait_cyc(k + LAT);
        e_fall(1'b0, f); e_settle();
        e_fall(1'b1, f); e_settle();
        e_fall(1'b0, f); e_settle();
        e_fall(1'b0, f); e_settle();
        check_eq("still_halting", 32'(state), 32'd1);
        e_fall(1'b0, f);
        push(ID_BUSREQ, 1, f + LAT);
        push(ID_GNT, 1, f + LAT + G);
        e_settle();
        wait_cyc(f + LAT + G + 2);
        release_halted();
        repeat (3) @(negedge clk);

        // CoCo off: no halt, fixed grant latency, no UNHALT wait on release.
        c_power = 1'b0;
        request_off(k);
        wait_cyc(k + 12);
        check_eq("off_halt_n", 32'(halt_n), 32'd1);
        release_off();
        repeat (3) @(negedge clk);

        // Watchdog: grant lasts TIMEOUT clk, then lockout until request drops.
        request_off(k);
        push(ID_GNT, 0, k + 1 + G + 2 + TIMEOUT);
        push(ID_TIMEOUT, 1, k + 1 + G + 2 + TIMEOUT);
        push(ID_TIMEOUT, 0, k + 1 + G + 2 + TIMEOUT + 1);
        push(ID_BUSREQ, 0, k + 1 + G + 2 + TIMEOUT + G);
        wait_cyc(k + 5000);
        check_eq("locked_out_state", 32'(state), 32'd0);
        ard_req = 1'b0;
        p = cyc;
        wait_cyc(p + 5);
        request_off(k);
        wait_cyc(k + 10);
        check_eq("regrant_state", 32'(state), 32'd3);
        release_off();
        repeat (3) @(negedge clk);

        // Request withdrawn while halting: abort without any grant.
        c_power = 1'b1;
        k = cyc;
        ard_req = 1'b1;
        push(ID_HALT_N, 0, k + LAT);
        wait_cyc(k + 5);
        ard_req = 1'b0;
        p = cyc;
        push(ID_HALT_N, 1, p + LAT + G);
        wait_cyc(p + LAT + G + 2);
        check_eq("abort_idle", 32'(state), 32'd0);
        repeat (3) @(negedge clk);

        // Arduino unplugged mid-grant: drop bus on the next edge, go through UNHALT.
        c_power = 1'b0;
        request_off(k);
        wait_cyc(k + 10);
        a_power = 1'b0;
        p = cyc;
        push(ID_BUSREQ, 0, p + 1);
        push(ID_GNT, 0, p + 1);
        wait_cyc(p + 2);
        check_eq("apower_unhalt", 32'(state), 32'd5);
        ard_req = 1'b0;
        wait_cyc(p + 7);
        check_eq("apower_idle", 32'(state), 32'd0);
        a_power = 1'b1;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a grant.
        request_off(k);
        wait_cyc(k + 10);
        check_eq("pre_reset_gnt", 32'(ard_gnt), 32'd1);
        push(ID_BUSREQ, 0, k + 11);
        push(ID_GNT, 0, k + 11);
        #2 rst = 1'b1;
        #1 check_outputs_reset("async_reset");
        ard_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        check_eq("pending", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
